// File: rtl/rtx_pkg.sv
// Shared scene types and constants for the renderer front end.
package rtx_pkg;

    // One scene object word; the first byte received lands in the low byte.
    typedef struct packed {
        logic [7:0] color;
        logic [7:0] shape;
    } object;

    localparam int unsigned SCENE_BUFFER_DEPTH = 4;
    localparam logic [7:0]  SCENE_SYNC_BYTE    = 8'hA5;

    typedef enum logic [2:0] {
        StSync,
        StCount,
        StPayload,
        StWrite,
        StCheck
    } loader_state_e;

    // Bytes needed to carry an object of the given bit width.
    function automatic int unsigned obj_bytes(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/scene_byte_assembler.sv
// Little-endian byte-to-word assembler: shift-in register plus byte index counter.
module scene_byte_assembler #(
    parameter int unsigned OBJ_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   shift_i,
    input  logic [7:0]             byte_i,
    output logic [OBJ_BYTES*8-1:0] word_next_o,
    output logic                   last_o
);

    localparam int unsigned IW = (OBJ_BYTES > 1) ? $clog2(OBJ_BYTES) : 1;

    logic [IW-1:0] idx_q;

    assign last_o = (idx_q == IW'(OBJ_BYTES - 1));

    generate
        if (OBJ_BYTES == 1) begin : g_single
            assign word_next_o = byte_i;
        end else begin : g_multi
            logic [OBJ_BYTES*8-1:0] word_q;

            // New bytes enter at the top so the first byte ends up in bits [7:0].
            assign word_next_o = {byte_i, word_q[OBJ_BYTES*8-1:8]};

            // Shift register for the partially assembled object.
            always_ff @(posedge clk) begin
                if (rst || clear_i) begin
                    word_q <= '0;
                end else if (shift_i) begin
                    word_q <= word_next_o;
                end
            end
        end
    endgenerate

    // Byte index within the current object, wrapping after the last byte.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q <= '0;
        end else if (shift_i) begin
            idx_q <= last_o ? '0 : idx_q + IW'(1);
        end
    end

endmodule

// File: rtl/scene_loader.sv
// Scene loader: parses sync/count/payload[/checksum] frames into scene buffer port A writes.
// Build option: define SCENE_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module scene_loader
    import rtx_pkg::*;
#(
    parameter int unsigned OBJ_BITS = $bits(object),
    parameter int unsigned DEPTH    = SCENE_BUFFER_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [OBJ_BITS-1:0]        wr_data,
    output logic [$clog2(DEPTH+1)-1:0] num_objs,
    output logic                       busy,
    output logic                       load_done,
    output logic                       load_err
);

    localparam int unsigned OBJ_BYTES = obj_bytes(OBJ_BITS);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = $clog2(DEPTH + 1);

    loader_state_e state_q, state_d;

    logic [7:0]             count_q;
    logic [7:0]             obj_idx_q;
    logic [AW-1:0]          wr_addr_q;
    logic [OBJ_BITS-1:0]    wr_data_q;
    logic [CW-1:0]          num_objs_q;
    logic                   done_q;
    logic                   err_q;
`ifdef SCENE_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q;
`endif

    logic                   accept;
    logic                   count_bad;
    logic                   last_obj;
    logic                   asm_last;
    logic [OBJ_BYTES*8-1:0] asm_word;

    assign accept    = in_valid && in_ready;
    assign count_bad = (in_data == 8'd0) || (32'(in_data) > DEPTH);
    assign last_obj  = (obj_idx_q + 8'd1) == count_q;

    scene_byte_assembler #(
        .OBJ_BYTES (OBJ_BYTES)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (state_q == StCount && accept),
        .shift_i     (state_q == StPayload && accept),
        .byte_i      (in_data),
        .word_next_o (asm_word),
        .last_o      (asm_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; no input timeout, so in_valid low simply holds the state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync:    if (accept && in_data == SCENE_SYNC_BYTE) state_d = StCount;
            StCount:   if (accept) state_d = count_bad ? StSync : StPayload;
            StPayload: if (accept && asm_last) state_d = StWrite;
`ifdef SCENE_LOADER_CHECKSUM_EN
            StWrite:   state_d = last_obj ? StCheck : StPayload;
`else
            StWrite:   state_d = last_obj ? StSync : StPayload;
`endif
            StCheck:   if (accept) state_d = StSync;
            default:   state_d = StSync;
        endcase
    end

    // Moore outputs; reset forces the handshake and strobe low immediately.
    always_comb begin
        in_ready  = !rst && (state_q != StWrite);
        wr_en     = !rst && (state_q == StWrite);
        busy      = !rst && (state_q != StSync);
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        num_objs  = num_objs_q;
        load_done = done_q;
        load_err  = err_q;
    end

    // Frame datapath: count, object index, write capture, checksum and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            obj_idx_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            num_objs_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SCENE_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StSync: begin
`ifdef SCENE_LOADER_CHECKSUM_EN
                    if (accept && in_data == SCENE_SYNC_BYTE) csum_q <= '0;
`endif
                end
                StCount: begin
                    if (accept) begin
                        count_q   <= in_data;
                        obj_idx_q <= '0;
                        err_q     <= count_bad;
                    end
                end
                StPayload: begin
                    if (accept) begin
`ifdef SCENE_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        // Capture the finished word now so it stays stable after WRITE.
                        if (asm_last) begin
                            wr_data_q <= asm_word[OBJ_BITS-1:0];
                            wr_addr_q <= obj_idx_q[AW-1:0];
                        end
                    end
                end
                StWrite: begin
                    obj_idx_q <= obj_idx_q + 8'd1;
`ifndef SCENE_LOADER_CHECKSUM_EN
                    if (last_obj) begin
                        done_q     <= 1'b1;
                        num_objs_q <= CW'(count_q);
                    end
`endif
                end
                StCheck: begin
`ifdef SCENE_LOADER_CHECKSUM_EN
                    if (accept) begin
                        if (in_data == csum_q) begin
                            done_q     <= 1'b1;
                            num_objs_q <= CW'(count_q);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scene_loader.sv
// Directed self-checking bench for scene_loader (DEPTH=4, OBJ_BITS=16).
module tb_scene_loader;

`ifdef SCENE_LOADER_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  num_objs;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    scene_loader #(
        .OBJ_BITS (16),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .num_objs  (num_objs),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Event log sampled mid-cycle.
    int          wr_cnt     = 0;
    int          done_cnt   = 0;
    int          err_cnt    = 0;
    int          ready_viol = 0;
    logic [1:0]  log_addr[64];
    logic [15:0] log_data[64];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = wr_addr;
                log_data[wr_cnt] = wr_data;
            end
            wr_cnt++;
            if (in_ready !== 1'b0) ready_viol++;
        end
        if (load_done === 1'b1) done_cnt++;
        if (load_err === 1'b1) err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_byte: in_ready stuck at %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(3);
        checks++;
        if ({in_ready, wr_en, busy, load_done, load_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000",
                     {in_ready, wr_en, busy, load_done, load_err});
        end
        checks++;
        if (wr_addr !== 2'd0 || wr_data !== 16'h0 || num_objs !== 3'd0) begin
            failures++;
            $display("FAIL reset_regs: got addr=%0h data=%0h num=%0d required 0 0 0",
                     wr_addr, wr_data, num_objs);
        end
        rst = 1'b0;
        idle(1);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_good_frame();
        int w0, d0, e0;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        if (CsumEn) send_byte(8'h44);
        idle(3);
        checks++;
        if (wr_cnt - w0 != 2) begin
            failures++;
            $display("FAIL good_writes: got %0d required 2", wr_cnt - w0);
        end else begin
            checks++;
            if (log_addr[w0] !== 2'd0 || log_data[w0] !== 16'h2211) begin
                failures++;
                $display("FAIL good_w0: got %0h/%0h required 0/2211", log_addr[w0], log_data[w0]);
            end
            checks++;
            if (log_addr[w0+1] !== 2'd1 || log_data[w0+1] !== 16'h4433) begin
                failures++;
                $display("FAIL good_w1: got %0h/%0h required 1/4433",
                         log_addr[w0+1], log_data[w0+1]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL good_pulses: got done=%0d err=%0d required 1 0",
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (num_objs !== 3'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL good_status: got num=%0d busy=%b required 2 0", num_objs, busy);
        end
        checks++;
        if (wr_addr !== 2'd1 || wr_data !== 16'h4433) begin
            failures++;
            $display("FAIL good_hold: got %0h/%0h required 1/4433", wr_addr, wr_data);
        end
    endtask

    task automatic test_bad_checksum();
        int w0, d0, e0;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h00);
        idle(3);
        checks++;
        if (wr_cnt - w0 != 2) begin
            failures++;
            $display("FAIL badsum_writes: got %0d required 2", wr_cnt - w0);
        end else begin
            checks++;
            if (log_data[w0] !== 16'h6655 || log_data[w0+1] !== 16'h8877) begin
                failures++;
                $display("FAIL badsum_data: got %0h %0h required 6655 8877",
                         log_data[w0], log_data[w0+1]);
            end
        end
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL badsum_pulses: got done=%0d err=%0d required 0 1",
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (num_objs !== 3'd2) begin
            failures++;
            $display("FAIL badsum_num: got %0d required 2", num_objs);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] counts[2];
        int w0, d0, e0;
        counts[0] = 8'h05;
        counts[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
            send_byte(8'hA5);
            send_byte(counts[i]);
            idle(3);
            checks++;
            if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || wr_cnt - w0 != 0) begin
                failures++;
                $display("FAIL badcount_%0h: got err=%0d done=%0d wr=%0d required 1 0 0",
                         counts[i], err_cnt - e0, done_cnt - d0, wr_cnt - w0);
            end
            checks++;
            if (busy !== 1'b0 || num_objs !== 3'd2) begin
                failures++;
                $display("FAIL badcount_state_%0h: got busy=%b num=%0d required 0 2",
                         counts[i], busy, num_objs);
            end
        end
    endtask

    task automatic test_leading_junk();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL junk_idle: got busy=%b required 0", busy);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
        if (CsumEn) send_byte(8'h66);
        idle(3);
        checks++;
        if (wr_cnt - w0 != 1 || log_addr[w0] !== 2'd0 || log_data[w0] !== 16'hCDAB) begin
            failures++;
            $display("FAIL junk_write: got n=%0d %0h/%0h required 1 0/cdab",
                     wr_cnt - w0, log_addr[w0], log_data[w0]);
        end
        checks++;
        if (done_cnt - d0 != 1 || num_objs !== 3'd1) begin
            failures++;
            $display("FAIL junk_done: got done=%0d num=%0d required 1 1", done_cnt - d0, num_objs);
        end
    endtask

    // Full-depth frame with random idle gaps between bytes.
    task automatic test_stall_full_depth();
        logic [7:0] bytes[10];
        int w0, d0, e0;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h04;
        for (int i = 0; i < 8; i++) bytes[2+i] = 8'(i + 1);
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(0, 4));
            send_byte(bytes[i]);
        end
        if (CsumEn) begin
            idle($urandom_range(0, 4));
            send_byte(8'h08);
        end
        idle(3);
        checks++;
        if (wr_cnt - w0 != 4) begin
            failures++;
            $display("FAIL stall_writes: got %0d required 4", wr_cnt - w0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_addr[w0+k] !== 2'(k) ||
                    log_data[w0+k] !== {8'(2*k + 2), 8'(2*k + 1)}) begin
                    failures++;
                    $display("FAIL stall_w%0d: got %0h/%0h required %0h/%0h", k,
                             log_addr[w0+k], log_data[w0+k], k, {8'(2*k + 2), 8'(2*k + 1)});
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || num_objs !== 3'd4) begin
            failures++;
            $display("FAIL stall_done: got done=%0d err=%0d num=%0d required 1 0 4",
                     done_cnt - d0, err_cnt - e0, num_objs);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0, d0, e0;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        rst = 1'b1;
        idle(1);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || num_objs !== 3'd0) begin
            failures++;
            $display("FAIL midrst_state: got busy=%b ready=%b num=%0d required 0 0 0",
                     busy, in_ready, num_objs);
        end
        idle(2);
        rst = 1'b0;
        idle(3);
        checks++;
        if (wr_cnt - w0 != 0 || done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got wr=%0d done=%0d err=%0d required 0 0 0",
                     wr_cnt - w0, done_cnt - d0, err_cnt - e0);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
        if (CsumEn) send_byte(8'h66);
        idle(3);
        checks++;
        if (wr_cnt - w0 != 1 || log_data[w0] !== 16'hCDAB || num_objs !== 3'd1 ||
            done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL midrst_reload: got wr=%0d data=%0h num=%0d done=%0d required 1 cdab 1 1",
                     wr_cnt - w0, log_data[w0], num_objs, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef SCENE_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_bad_count();
        test_leading_junk();
        test_stall_full_depth();
        test_reset_mid_frame();
        checks++;
        if (ready_viol != 0) begin
            failures++;
            $display("FAIL ready_in_write: got %0d cycles with in_ready high, required 0",
                     ready_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scene_loader.md
SCENE_LOADER -- requirements
Module: scene_loader

Interface
REQ-001 SHALL have parameter OBJ_BITS, default $bits(object): width of one scene object word.
REQ-002 SHALL have parameter DEPTH, default SCENE_BUFFER_DEPTH: number of scene buffer slots.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  8  incoming byte stream.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port wr_en  output  1  write strobe to scene buffer port A (wea).
REQ-009 SHALL have port wr_addr  output  $clog2(DEPTH)  write slot (addra).
REQ-010 SHALL have port wr_data  output  OBJ_BITS  object word (dina).
REQ-011 SHALL have port num_objs  output  $clog2(DEPTH+1)  object count of last successful load.
REQ-012 SHALL have port busy  output  1  high in any state other than SYNC.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse on successful frame end.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-015 Frame format SHALL be: sync byte SCENE_SYNC_BYTE (0xA5), count byte N, N objects of OBJ_BYTES = ceil(OBJ_BITS/8) bytes each, then a checksum byte.
REQ-016 Object bytes SHALL be assembled little-endian (first byte -> wr_data[7:0]); padding bits above OBJ_BITS SHALL be discarded.
REQ-017 FSM states SHALL be SYNC, COUNT, PAYLOAD, WRITE, CHECK.
REQ-018 SYNC: bytes other than 0xA5 SHALL be consumed and ignored; 0xA5 -> COUNT.
REQ-019 COUNT: N in 1..DEPTH -> PAYLOAD with slot 0 and byte index 0; N = 0 or N > DEPTH -> load_err pulse next cycle and return to SYNC.
REQ-020 PAYLOAD: on accepting the last byte of an object -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle with wr_en = 1 and in_ready = 0; wr_addr SHALL equal the object index (0..N-1); then -> PAYLOAD if more objects remain, else CHECK.
REQ-022 in_ready SHALL be 1 in every state except WRITE and except while rst is high.
REQ-023 CHECK: checksum = XOR of all payload bytes (excluding sync and count); on match load_done SHALL pulse the cycle after acceptance and num_objs <= N; on mismatch load_err SHALL pulse and num_objs SHALL be unchanged; both -> SYNC.
REQ-024 Objects already written before a checksum mismatch SHALL remain in memory; no rollback.
REQ-025 wr_en SHALL never assert outside WRITE; wr_addr/wr_data SHALL hold their last values when wr_en = 0.
REQ-026 in_valid low SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-027 On rst: state SYNC, in_ready 0 during reset, wr_en 0, wr_addr 0, wr_data 0, num_objs 0, busy 0, load_done 0, load_err 0, checksum accumulator 0.
REQ-028 rst mid-frame SHALL abandon the frame with no further writes and no done/err pulse.

Configuration
REQ-029 With SCENE_LOADER_CHECKSUM_EN defined, CHECK and the checksum byte SHALL exist as in REQ-023.
REQ-030 Without SCENE_LOADER_CHECKSUM_EN, no checksum byte SHALL be expected; after the final WRITE the FSM SHALL pulse load_done, set num_objs <= N, and go to SYNC; load_err arises only from REQ-019.

Structure
REQ-031 SCENE_SYNC_BYTE SHALL live in the shared rtx package alongside object and SCENE_BUFFER_DEPTH.
REQ-032 Byte-to-word assembly SHALL be one sub-module, scene_byte_assembler (shift-in register plus byte index counter, clear on frame start).
REQ-033 Outputs wr_en/wr_addr/wr_data SHALL connect directly to scene_buffer's memory port A.

Verification (DEPTH=4, OBJ_BITS=16, checksum enabled unless stated)
REQ-034 A5,02,11,22,33,44,44 -> wr_en at addr0 data 0x2211, addr1 data 0x4433, load_done pulse, num_objs = 2.
REQ-035 A5,02,11,22,33,44,00 -> both writes occur, load_err pulse, num_objs keeps prior value.
REQ-036 A5,05 -> load_err pulse, no wr_en, back to SYNC; A5,00 likewise.
REQ-037 00,FF,A5,01,AB,CD,66 -> leading bytes ignored, addr0 data 0xCDAB, load_done, num_objs = 1.
REQ-038 rst asserted after A5,02,11 -> no wr_en, busy 0, num_objs 0; next valid frame loads normally.
REQ-039 Macro undefined: A5,01,AB,CD -> write addr0 data 0xCDAB, load_done, num_objs = 1; in_valid toggled randomly gives identical result.
